// File: rtl/uc_ctrl_pipe.sv
// uc_ctrl_pipe: registered control-word pipeline (SelC/Type/MR/MW) from decode
// to the memory/writeback side, with HOLD bubble injection, FLUSH, memory-busy
// freeze and per-stage valid tracking.
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   SelC_in, Type_in      decoded control word of the incoming instruction
//   MR_IN, MW_IN          memory read/write request of the incoming word
//   VALID_IN              incoming word is a real instruction
//   HOLD                  hazard: insert HOLD_LEN bubbles starting this cycle
//   FLUSH                 kill every in-flight word
//   MEM_BUSY              freeze the whole pipe this cycle
//   STALL_OUT             upstream must hold its word (combinational)
//   SelC_out, Type_out    last-stage control word, NOP when invalid
//   MR_OUT, MW_OUT        last-stage memory requests gated by valid
//   VALID_OUT             last stage holds a real instruction
//   STAGE_VALID           valid bit per stage, bit0 = entry stage
//
// Optional macro UC_CTRL_PIPE_STATS_EN adds saturating BUBBLE_CNT/FREEZE_CNT.
module uc_ctrl_pipe #(
  parameter int unsigned SELC_W   = 6,
  parameter int unsigned TYPE_W   = 7,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned HOLD_LEN = 1,
  parameter int unsigned NOP_SELC = 35,
  parameter int unsigned NOP_TYPE = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [SELC_W-1:0] SelC_in,
  input  logic [TYPE_W-1:0] Type_in,
  input  logic              MR_IN,
  input  logic              MW_IN,
  input  logic              VALID_IN,
  input  logic              HOLD,
  input  logic              FLUSH,
  input  logic              MEM_BUSY,
  output logic              STALL_OUT,
  output logic [SELC_W-1:0] SelC_out,
  output logic [TYPE_W-1:0] Type_out,
  output logic              MR_OUT,
  output logic              MW_OUT,
  output logic              VALID_OUT,
  output logic [DEPTH-1:0]  STAGE_VALID
`ifdef UC_CTRL_PIPE_STATS_EN
  ,
  output logic [15:0]       BUBBLE_CNT,
  output logic [15:0]       FREEZE_CNT
`endif
);

  localparam int unsigned CNT_W = $clog2(HOLD_LEN + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_LEN - 1);

  typedef struct packed {
    logic [SELC_W-1:0] selc;
    logic [TYPE_W-1:0] typ;
    logic              mr;
    logic              mw;
    logic              valid;
  } stage_t;

  localparam stage_t BUBBLE_STAGE = {SELC_W'(NOP_SELC), TYPE_W'(NOP_TYPE), 3'b000};

  typedef enum logic [1:0] {ST_RUN, ST_BUBBLE, ST_FROZEN} state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_t           stage_q [DEPTH];
  stage_t           stage_d [DEPTH];
  stage_t           in_word;
  stage_t           last;
  logic             bubble_active;

  // State, counter and stage registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= BUBBLE_STAGE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // Next-state, stage shift and stall logic.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(DEPTH); i++) stage_d[i] = stage_q[i];
    in_word = VALID_IN ? {SelC_in, Type_in, MR_IN, MW_IN, 1'b1} : BUBBLE_STAGE;
    // Once MEM_BUSY drops, the frozen pipe behaves as the remembered state
    // in that same cycle so STALL_OUT and the shift stay consistent.
    eff_state     = (state_q == ST_FROZEN) ? ret_q : state_q;
    bubble_active = (eff_state == ST_BUBBLE) && (cnt_q != '0);

    if (FLUSH) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_d[i] = BUBBLE_STAGE;
      cnt_d   = '0;
      state_d = ST_RUN;
      ret_d   = ST_RUN;
    end else if (MEM_BUSY) begin
      state_d = ST_FROZEN;
      if (state_q != ST_FROZEN) ret_d = state_q;
    end else begin
      for (int i = 1; i < int'(DEPTH); i++) stage_d[i] = stage_q[i-1];
      if (HOLD) begin
        // A new HOLD reloads rather than accumulates.
        stage_d[0] = BUBBLE_STAGE;
        cnt_d      = RELOAD;
        state_d    = (RELOAD != '0) ? ST_BUBBLE : ST_RUN;
      end else if (bubble_active) begin
        stage_d[0] = BUBBLE_STAGE;
        cnt_d      = cnt_q - CNT_W'(1);
        state_d    = (cnt_q == CNT_W'(1)) ? ST_RUN : ST_BUBBLE;
      end else begin
        stage_d[0] = in_word;
        state_d    = ST_RUN;
      end
    end

    STALL_OUT = FLUSH ? 1'b0 : (HOLD | MEM_BUSY | bubble_active);
  end

  // Outputs come straight from the last stage register, forced to NOP when invalid.
  assign last      = stage_q[DEPTH-1];
  assign VALID_OUT = last.valid;
  assign SelC_out  = last.valid ? last.selc : SELC_W'(NOP_SELC);
  assign Type_out  = last.valid ? last.typ  : TYPE_W'(NOP_TYPE);
  assign MR_OUT    = last.mr & last.valid;
  assign MW_OUT    = last.mw & last.valid;

  always_comb begin
    STAGE_VALID = '0;
    for (int i = 0; i < int'(DEPTH); i++) STAGE_VALID[i] = stage_q[i].valid;
  end

`ifdef UC_CTRL_PIPE_STATS_EN
  logic bubble_ins;
  logic freeze_cyc;

  assign bubble_ins = !FLUSH && !MEM_BUSY && (HOLD || bubble_active);
  assign freeze_cyc = !FLUSH && MEM_BUSY;

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUBBLE_CNT <= 16'd0;
      FREEZE_CNT <= 16'd0;
    end else begin
      if (bubble_ins && (BUBBLE_CNT != 16'hFFFF)) BUBBLE_CNT <= BUBBLE_CNT + 16'd1;
      if (freeze_cyc && (FREEZE_CNT != 16'hFFFF)) FREEZE_CNT <= FREEZE_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: doc/uc_ctrl_pipe.md
Name: uc_ctrl_pipe

Overview:
- Parametrised control-word pipeline: carries SelC/Type/MR/MW through DEPTH registered stages from decode to the memory/writeback side.
- Next generation of the combinational hold-to-NOP stage: adds real registering, multi-cycle bubble injection from a single HOLD pulse, flush, memory-busy freeze and per-stage valid tracking.
- Sits between the decoder and the datapath select/memory control inputs.

Parameters:
SELC_W, 6, width of SelC control word
TYPE_W, 7, width of Type control word
DEPTH, 3, number of pipeline stages (>=1)
HOLD_LEN, 1, bubbles inserted per HOLD pulse (>=1)
NOP_SELC, 35, SelC value of a bubble
NOP_TYPE, 0, Type value of a bubble

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
SelC_in  in  SELC_W  decoded register-select word
Type_in  in  TYPE_W  decoded instruction type
MR_IN  in  1  memory-read request of incoming word
MW_IN  in  1  memory-write request of incoming word
VALID_IN  in  1  incoming word is a real instruction
HOLD  in  1  hazard detected: insert HOLD_LEN bubbles
FLUSH  in  1  kill all in-flight words
MEM_BUSY  in  1  memory not ready: freeze whole pipe
STALL_OUT  out  1  upstream must hold its word this cycle
SelC_out  out  SELC_W  last-stage SelC
Type_out  out  TYPE_W  last-stage Type
MR_OUT  out  1  last-stage MR, gated by valid
MW_OUT  out  1  last-stage MW, gated by valid
VALID_OUT  out  1  last stage holds a real instruction
STAGE_VALID  out  DEPTH  valid bit per stage, bit0 = entry stage

Behaviour:
- Reset (RST_N low, async): every stage = {NOP_SELC, NOP_TYPE, MR=0, MW=0, valid=0}; FSM = RUN; bubble counter = 0; all outputs = NOP/0.
- Bubble stage: SelC=NOP_SELC, Type=NOP_TYPE, MR=MW=0, valid=0.
- Latency: word accepted at edge k appears on outputs after edge k+DEPTH-1 (DEPTH=1: registered once, visible after the same edge).
- Outputs driven from last stage. MR_OUT/MW_OUT = stage bit AND valid. SelC_out/Type_out are forced to NOP values when invalid.
- Bubble counter width $clog2(HOLD_LEN+1).
- FSM states:
  - RUN: normal shift; stage0 <= input word (bubble if VALID_IN=0).
  - BUBBLE: counter>0; stage0 <= bubble, stages 1..DEPTH-1 shift, counter decrements.
  - FROZEN: MEM_BUSY=1; no stage or counter changes; outputs held stable (MR/MW stay as a level for the memory handshake).
- Transitions:
  - HOLD in RUN: this cycle stage0 <= bubble (input not taken); counter <= HOLD_LEN-1; go BUBBLE if counter>0, else stay RUN.
  - HOLD in BUBBLE: counter reloads to HOLD_LEN-1 (no accumulation).
  - Counter reaches 0 in BUBBLE: next cycle RUN.
  - MEM_BUSY=1 from any state: FROZEN; remembers the return state. MEM_BUSY=0: return to the remembered state.
- Priority, per cycle: RST_N > FLUSH > MEM_BUSY > HOLD > normal.
  - FLUSH: all stages <= bubble, counter <= 0, state <= RUN, even if MEM_BUSY or HOLD is high.
- STALL_OUT = HOLD | (state==BUBBLE) | MEM_BUSY, combinational; forced 0 during FLUSH.
- Mid-operation reset clears the counter and FSM immediately, with no extra bubble.

Optional Feature:
- Macro UC_CTRL_PIPE_STATS_EN.
- When defined, adds outputs BUBBLE_CNT[15:0] and FREEZE_CNT[15:0], both reset to 0:
  - BUBBLE_CNT increments each cycle a bubble enters stage0 due to HOLD or BUBBLE state.
  - FREEZE_CNT increments each FROZEN cycle.
  - Both saturate at 16'hFFFF, are cleared only by reset, and are unaffected by FLUSH.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then stream SelC 1,2,3 with VALID_IN=1, DEPTH=3 -> SelC_out 1,2,3 on cycles 3,4,5; STAGE_VALID reaches 3'b111.
- Stream plus a single-cycle HOLD with HOLD_LEN=2 -> two consecutive outputs SelC=35, Type=0, MR=MW=0; STALL_OUT high 2 cycles; no input word lost or duplicated.
- Last stage has MR_IN=1 word, MEM_BUSY high 4 cycles -> MR_OUT stays 1 and SelC_out stable for 4 cycles; resumes order afterwards.
- FLUSH with HOLD and MEM_BUSY also high and counter=1 -> next cycle STAGE_VALID=0, VALID_OUT=0, STALL_OUT=0, FSM RUN.
- RST_N asserted asynchronously mid-BUBBLE -> outputs NOP/0 before the next edge; after release, the first valid input exits after DEPTH-1 edges with no stray bubble.
- With UC_CTRL_PIPE_STATS_EN and HOLD_LEN=2: 3 HOLD pulses plus 5 MEM_BUSY cycles -> BUBBLE_CNT=6, FREEZE_CNT=5.
